// File: rtl/rv_mc_if.sv
// rv_mc_if: fetch/data handshakes plus the control bundle between rv_mc_ctrl and the datapath.
// The master side is the sequencer; the slave side is memory and datapath.
interface rv_mc_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             imem_req;
   logic [XLEN-1:0]  imem_addr;
   logic             imem_ack;
   logic [31:0]      imem_rdata;
   logic             dmem_ack;
   logic             zero;
   logic [XLEN-1:0]  imm;
   logic [31:0]      ins;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pc_plus4;
   logic             RegWrite;
   logic             ALUSrc;
   logic [2:0]       op;
   logic             MemRead;
   logic             MemWrite;
   logic             Mem2Reg;
   logic             link_sel;
   logic             halted;
   logic             trap;
   logic [CNT_W-1:0] instret;

   modport master (
      output imem_req, imem_addr, ins, pc, pc_plus4, RegWrite, ALUSrc, op,
             MemRead, MemWrite, Mem2Reg, link_sel, halted, trap, instret,
      input  imem_ack, imem_rdata, dmem_ack, zero, imm
   );

   modport slave (
      input  imem_req, imem_addr, ins, pc, pc_plus4, RegWrite, ALUSrc, op,
             MemRead, MemWrite, Mem2Reg, link_sel, halted, trap, instret,
      output imem_ack, imem_rdata, dmem_ack, zero, imm
   );
endinterface

// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR and instret.
// Every control output is a decode of registered state, so strobes drop as soon as reset lands.
module rv_mc_ctrl #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 'h28,
   parameter int              CNT_W    = 16
) (
   input  logic    clk,
   input  logic    reset,
   rv_mc_if.master bus
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   logic [2:0]       state_reg;
   logic [XLEN-1:0]  pc_reg;
   logic [31:0]      ins_reg;
   logic [CNT_W-1:0] instret_reg;
   logic             trap_reg;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            is_r, is_addi, is_lw, is_sw, is_br, is_jal, legal;
   logic            taken, retiring;
   logic [XLEN-1:0] pc_seq, pc_tgt, retire_pc;

   assign opcode  = ins_reg[6:0];
   assign funct3  = ins_reg[14:12];
   assign is_r    = (opcode == 7'h33);
   assign is_addi = (opcode == 7'h13);
   assign is_lw   = (opcode == 7'h03);
   assign is_sw   = (opcode == 7'h23);
   assign is_br   = (opcode == 7'h63) && (funct3[2:1] == 2'b00);
   assign is_jal  = (opcode == 7'h6F);
   assign legal   = is_r | is_addi | is_lw | is_sw | is_br | is_jal;

   // funct3[0] distinguishes bne from beq
   assign taken  = funct3[0] ? ~bus.zero : bus.zero;
   assign pc_seq = pc_reg + XLEN'(4);
   assign pc_tgt = pc_reg + (bus.imm << 1);

   assign retiring = ((state_reg == S_EXEC) && is_br) ||
                     ((state_reg == S_MEM) && is_sw && bus.dmem_ack) ||
                     (state_reg == S_WB);
   assign retire_pc = (((state_reg == S_EXEC) && is_br && taken) ||
                       ((state_reg == S_WB) && is_jal)) ? pc_tgt : pc_seq;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= S_FETCH;
         pc_reg      <= RESET_PC;
         ins_reg     <= '0;
         instret_reg <= '0;
         trap_reg    <= 1'b0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               if (bus.imem_ack) begin
                  ins_reg   <= bus.imem_rdata;
                  state_reg <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (legal) begin
                  state_reg <= S_EXEC;
               end else begin
                  state_reg <= S_HALT;
                  trap_reg  <= 1'b1;
               end
            end
            S_EXEC: begin
               if (is_lw || is_sw) state_reg <= S_MEM;
               else if (!is_br)    state_reg <= S_WB;
            end
            S_MEM: begin
               if (bus.dmem_ack && is_lw) state_reg <= S_WB;
            end
            S_WB, S_HALT: ;
            default: state_reg <= S_HALT;
         endcase

         // A misaligned next pc halts without committing pc or instret
         if (retiring) begin
            if (retire_pc[1:0] != 2'b00) begin
               state_reg <= S_HALT;
               trap_reg  <= 1'b1;
            end else begin
               pc_reg      <= retire_pc;
               instret_reg <= instret_reg + 1'b1;
               state_reg   <= S_FETCH;
            end
         end
      end
   end

   assign bus.imem_req  = (state_reg == S_FETCH);
   assign bus.imem_addr = pc_reg;
   assign bus.ins       = ins_reg;
   assign bus.pc        = pc_reg;
   assign bus.pc_plus4  = pc_seq;
   assign bus.RegWrite  = (state_reg == S_WB);
   assign bus.ALUSrc    = is_addi | is_lw | is_sw;
   assign bus.op        = is_br ? 3'b110 : 3'b010;
   assign bus.MemRead   = (state_reg == S_MEM) && is_lw;
   assign bus.MemWrite  = (state_reg == S_MEM) && is_sw;
   assign bus.Mem2Reg   = is_lw && (state_reg != S_HALT);
   assign bus.link_sel  = is_jal && (state_reg != S_HALT);
   assign bus.halted    = (state_reg == S_HALT);
   assign bus.trap      = trap_reg;
   assign bus.instret   = instret_reg;
endmodule

// File: tb/tb_rv_mc_ctrl.sv
// tb_rv_mc_ctrl: directed test-plan sequences plus random instruction streams; a stimulus-side
// model queues per-instruction expectations and an independent monitor checks each completion.
module tb_rv_mc_ctrl;
   localparam int XLEN = 32, CNT_W = 16;
   localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

   typedef struct {
      int          kind;
      logic [31:0] next_pc;
      logic [15:0] instret;
      bit          halt;
      int          cycles;
      int          rw;
      int          mr;
      int          mw;
      bit          m2r;
      bit          link;
      logic        alusrc;
      logic [2:0]  op;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   rv_mc_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
   rv_mc_ctrl #(.XLEN(XLEN), .RESET_PC(32'h28), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .bus(bus.master)
   );

   always #5 clk = ~clk;

   exp_t        sb[$];
   int          checks = 0, errors = 0;
   logic [31:0] m_pc;
   logic [15:0] m_instret;
   bit          m_halt;
   logic [6:0]  ill_tab [8] = '{7'h7F, 7'h00, 7'h37, 7'h17, 7'h67, 7'h0F, 7'h73, 7'h63};

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: outcome of one instruction from the architectural rules
   function automatic exp_t model(int kind, logic [2:0] f3, logic [31:0] immv, bit zv, int iw, int dw);
      exp_t e;
      logic [31:0] tgt;
      bit tk;
      e.kind = kind; e.rw = 0; e.mr = 0; e.mw = 0; e.m2r = 0; e.link = 0; e.halt = 0;
      e.alusrc = (kind == K_ADDI || kind == K_LW || kind == K_SW);
      e.op = (kind == K_BR) ? 3'b110 : 3'b010;
      tgt = m_pc + 32'd4;
      case (kind)
         K_BR: begin
            tk = (f3 == 3'b000) ? zv : !zv;
            if (tk) tgt = m_pc + immv * 2;
            e.cycles = 3;
         end
         K_JAL: begin tgt = m_pc + immv * 2; e.cycles = 4; e.rw = 1; e.link = 1; end
         K_LW:  begin e.cycles = 5 + dw; e.rw = 1; e.mr = dw + 1; e.m2r = 1; end
         K_SW:  begin e.cycles = 4 + dw; e.mw = dw + 1; end
         K_ILL: begin e.cycles = 2; e.halt = 1; end
         default: begin e.cycles = 4; e.rw = 1; end
      endcase
      e.cycles += iw;
      if (tgt % 4 != 0) e.halt = 1;
      if (e.halt) begin
         m_halt = 1;
      end else begin
         m_pc = tgt;
         m_instret = m_instret + 16'd1;
      end
      e.next_pc = m_pc;
      e.instret = m_instret;
      return e;
   endfunction

   function automatic logic [31:0] encode(int kind, logic [2:0] f3, logic [6:0] ill_opc);
      logic [31:0] w;
      w = $urandom;
      case (kind)
         K_R:    w[6:0] = 7'h33;
         K_ADDI: w[6:0] = 7'h13;
         K_LW:   w[6:0] = 7'h03;
         K_SW:   w[6:0] = 7'h23;
         K_BR:   w[6:0] = 7'h63;
         K_JAL:  w[6:0] = 7'h6F;
         default: w[6:0] = ill_opc;
      endcase
      w[14:12] = f3;
      return w;
   endfunction

   // Monitor: one record per instruction, closed by the next fetch or by entering HALT
   bit          mon_active, mon_prev_req, mon_prev_halt, mon_start, mon_end_halt, mon_m2r, mon_link;
   int          mon_cyc, mon_rw, mon_mr, mon_mw, mon_wb_cyc;
   logic        mon_alusrc;
   logic [2:0]  mon_op;
   exp_t        mon_e;

   initial begin
      mon_active = 0; mon_prev_req = 0; mon_prev_halt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_active = 0; mon_prev_req = 0; mon_prev_halt = 0;
         end else begin
            mon_start    = bus.imem_req && !mon_prev_req;
            mon_end_halt = bus.halted && !mon_prev_halt;
            if (mon_active && (mon_start || mon_end_halt)) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL sb_underflow actual=completion expected=none @%0t", $time);
               end else begin
                  mon_e = sb.pop_front();
                  chk("cycles", mon_cyc, mon_e.cycles);
                  chk("halted", bus.halted, mon_e.halt);
                  chk("trap", bus.trap, mon_e.halt);
                  chk("pc", bus.pc, mon_e.next_pc);
                  chk("instret", bus.instret, mon_e.instret);
                  chk("regwrite_cycles", mon_rw, mon_e.rw);
                  chk("memread_cycles", mon_mr, mon_e.mr);
                  chk("memwrite_cycles", mon_mw, mon_e.mw);
                  if (mon_e.rw != 0) begin
                     chk("wb_is_last", mon_wb_cyc, mon_e.cycles);
                     chk("mem2reg", mon_m2r, mon_e.m2r);
                     chk("link_sel", mon_link, mon_e.link);
                  end
                  if (mon_e.kind != K_ILL && mon_e.kind != K_JAL) begin
                     chk("alusrc", mon_alusrc, mon_e.alusrc);
                     chk("alu_op", mon_op, mon_e.op);
                  end
                  if (!mon_e.halt) chk("imem_addr", bus.imem_addr, mon_e.next_pc);
                  $display("txn kind=%0d next_pc=%h instret=%0d cycles=%0d halted=%0b",
                           mon_e.kind, bus.pc, bus.instret, mon_cyc, bus.halted);
               end
            end
            if (mon_end_halt) mon_active = 0;
            if (mon_start) begin
               mon_active = 1; mon_cyc = 0; mon_rw = 0; mon_mr = 0; mon_mw = 0;
               mon_wb_cyc = 0; mon_m2r = 0; mon_link = 0;
            end
            if (mon_active) begin
               mon_cyc++;
               if (bus.RegWrite) begin
                  mon_rw++; mon_wb_cyc = mon_cyc; mon_m2r = bus.Mem2Reg; mon_link = bus.link_sel;
               end
               mon_mr += int'(bus.MemRead);
               mon_mw += int'(bus.MemWrite);
               mon_alusrc = bus.ALUSrc;
               mon_op = bus.op;
            end
            mon_prev_req  = bus.imem_req;
            mon_prev_halt = bus.halted;
         end
      end
   end

   task automatic do_reset();
      int n;
      bit bad;
      n = 0; bad = 0;
      while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("sb_drain", sb.size(), 0);
      if (m_halt) begin
         repeat (4) begin
            @(negedge clk);
            if (bus.imem_req || !bus.halted || bus.RegWrite || bus.MemRead || bus.MemWrite) bad = 1;
         end
         chk("halt_quiet", bad, 0);
      end
      #2 reset = 1'b1;
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      #1;
      chk("rst_pc", bus.pc, 32'h28);
      chk("rst_imem_addr", bus.imem_addr, 32'h28);
      chk("rst_ins", bus.ins, 0);
      chk("rst_instret", bus.instret, 0);
      chk("rst_halted_trap", {bus.halted, bus.trap}, 0);
      chk("rst_strobes", {bus.RegWrite, bus.MemRead, bus.MemWrite}, 0);
      chk("rst_alu", {bus.ALUSrc, bus.op}, 4'b0010);
      m_pc = 32'h28; m_instret = 0; m_halt = 0;
      @(posedge clk); @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_instr(input int kind, input logic [2:0] f3, input logic [6:0] ill_opc,
                            input logic [31:0] fixed, input logic [31:0] immv, input bit zv,
                            input int iw, input int dw, input bit rst_mid);
      logic [31:0] insw;
      exp_t e;
      int n;
      insw = (fixed != 0) ? fixed : encode(kind, f3, ill_opc);
      e = model(kind, f3, immv, zv, iw, dw);
      sb.push_back(e);
      n = 0;
      while (!bus.imem_req && n < 100) begin @(negedge clk); n++; end
      if (!bus.imem_req) begin
         chk("fetch_timeout", 0, 1);
         m_halt = 1;
         return;
      end
      bus.imm = immv; bus.zero = zv;
      repeat (iw) begin
         bus.imem_ack = 1'b0; bus.dmem_ack = 1'($urandom % 2);
         @(negedge clk);
      end
      bus.dmem_ack = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = insw;
      @(negedge clk);
      bus.imem_ack = 1'b0; bus.imem_rdata = $urandom;
      if (kind == K_LW || kind == K_SW) begin
         n = 0;
         while (!(bus.MemRead || bus.MemWrite) && n < 20) begin
            bus.imem_ack = 1'($urandom % 2);
            @(negedge clk); n++;
         end
         bus.imem_ack = 1'b0;
         if (!(bus.MemRead || bus.MemWrite)) begin
            chk("mem_timeout", 0, 1);
            m_halt = 1;
            return;
         end
         if (rst_mid && kind == K_SW) begin
            @(negedge clk);
            chk("sw_mem_active", bus.MemWrite, 1);
            #2 reset = 1'b1;
            #1;
            chk("midrst_memwrite", bus.MemWrite, 0);
            chk("midrst_pc", bus.pc, 32'h28);
            chk("midrst_instret", bus.instret, 0);
            sb.delete();
            m_pc = 32'h28; m_instret = 0; m_halt = 0;
            @(negedge clk); @(posedge clk);
            #2 reset = 1'b0;
            @(negedge clk);
            chk("post_rst_no_mem", {bus.MemRead, bus.MemWrite}, 0);
            chk("post_rst_fetch", bus.imem_req, 1);
         end else begin
            repeat (dw) begin
               bus.imem_ack = 1'($urandom % 2);
               @(negedge clk);
            end
            bus.imem_ack = 1'b0; bus.dmem_ack = 1'b1;
            @(negedge clk);
            bus.dmem_ack = 1'b0;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, v, iw, dw;
      logic [2:0] f3;
      logic [6:0] io;
      bus.imem_ack = 0; bus.dmem_ack = 0; bus.imem_rdata = 0; bus.zero = 0; bus.imm = 0;
      m_pc = 32'h28; m_instret = 0; m_halt = 0;
      do_reset();
      // Directed walk through the documented scenarios
      run_instr(K_ADDI, 3'd0, 7'h0, 32'h00400293, 32'd4, 0, 0, 0, 0);
      run_instr(K_ADDI, 3'd0, 7'h0, 0, 32'd4, 0, 0, 0, 0);
      run_instr(K_BR,   3'd0, 7'h0, 0, 32'd8, 1, 0, 0, 0);
      run_instr(K_JAL,  3'd0, 7'h0, 0, -32'sd4, 0, 0, 0, 0);
      run_instr(K_BR,   3'd0, 7'h0, 0, 32'd8, 0, 0, 0, 0);
      run_instr(K_BR,   3'd1, 7'h0, 0, 32'd8, 0, 0, 0, 0);
      run_instr(K_BR,   3'd1, 7'h0, 0, 32'd8, 1, 0, 0, 0);
      run_instr(K_LW,   3'd2, 7'h0, 0, 32'd0, 0, 0, 3, 0);
      run_instr(K_SW,   3'd2, 7'h0, 0, 32'd0, 0, 2, 1, 0);
      run_instr(K_ILL,  3'd0, 7'h7F, 0, 32'd0, 0, 0, 0, 0);
      do_reset();
      run_instr(K_BR,   3'd0, 7'h0, 0, 32'd1, 1, 0, 0, 0);
      do_reset();
      run_instr(K_ADDI, 3'd0, 7'h0, 0, 32'd0, 0, 0, 0, 0);
      run_instr(K_SW,   3'd2, 7'h0, 0, 32'd0, 0, 0, 5, 1);
      run_instr(K_ADDI, 3'd0, 7'h0, 0, 32'd0, 0, 1, 0, 0);
      // Random streams, each ending at a halt or after a fixed length
      for (int seg = 0; seg < 6; seg++) begin
         do_reset();
         for (int i = 0; i < 25 && !m_halt; i++) begin
            kind = $urandom_range(0, 5);
            if ($urandom_range(0, 29) == 0) kind = K_ILL;
            f3 = (kind == K_BR) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            io = ill_tab[$urandom_range(0, 7)];
            if (kind == K_ILL && io == 7'h63) f3 = 3'($urandom_range(2, 7));
            v = int'($urandom_range(0, 40)) - 20;
            if ($urandom_range(0, 7) != 0) v = v & ~1;
            iw = $urandom_range(0, 2);
            dw = $urandom_range(0, 3);
            run_instr(kind, f3, io, 0, v, 1'($urandom % 2), iw, dw, 0);
         end
      end
      do_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
